branch_resolve_unit: RTL and testbench

// - EX-stage consumer of the branch comparator's BrEq/BrLt; drives BrUn back to the comparator.
// - Decides the branch outcome and detects a mispredict against the fetch-time prediction.
// - Issues a registered redirect/flush to IF/ID.
// - Queues predictor-update records to the YAGS predictor through a valid/ready FIFO.

---
 rtl/branch_resolve_unit.sv | 150 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolve: decides EX branch/jump outcome, flags mispredicts, queues predictor updates.
// Latency: redirect/flush/err_funct3 one cycle after EX; updates visible at queue head one cycle after push.
// Backpressure: upd_valid/upd_ready handshake on queue head; stall_req when full, overflow push dropped.
module branch_resolve_unit #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_npc,
  input  logic             BrEq,
  input  logic             BrLt,
  output logic             BrUn,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [XLEN-1:0]  upd_pc,
  output logic             upd_taken,
  output logic             upd_mispred,
  output logic             stall_req,
  output logic             err_funct3,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispreds
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = XLEN + 2;

  logic            live;
  logic            illegal;
  logic            taken;
  logic [XLEN-1:0] actual_npc;
  logic            mispred;
  logic            push;
  logic            pop;
  logic            full;
  logic            push_wr;

  logic [PW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   hold;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  // The fetch-time direction is implied by ex_pred_npc; the bit itself is not needed here.
  logic unused_pred_taken;
  assign unused_pred_taken = ex_pred_taken;

  // Unsigned compare for BLTU/BGEU, which are exactly the funct3 codes with bit 1 set.
  assign BrUn = ex_funct3[1];

  // The instruction right after a flush is wrong-path, so redirect_valid doubles as the shadow.
  assign live    = ex_valid & ~redirect_valid;
  assign illegal = ex_is_branch & (ex_funct3[2:1] == 2'b01);

  // Branch direction from comparator flags; BrLt is ignored whenever BrEq is set.
  always_comb begin
    taken = 1'b0;
    if (!ex_is_branch) begin
      taken = 1'b1;
    end else begin
      case (ex_funct3)
        3'b000:          taken = BrEq;
        3'b001:          taken = ~BrEq;
        3'b100, 3'b110:  taken = ~BrEq & BrLt;
        3'b101, 3'b111:  taken = BrEq | ~BrLt;
        default:         taken = 1'b0;
      endcase
    end
  end

  assign actual_npc = taken ? ex_target : ex_pc + XLEN'(4);
  assign mispred    = live & (actual_npc != ex_pred_npc);

  assign push    = live & ex_is_branch & ~illegal;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = upd_valid & upd_ready;
  // While full a push only lands if the head leaves in the same cycle.
  assign push_wr = push & (~full | pop);

  assign stall_req = full;
  assign upd_valid = (count != '0);
  // With the queue empty the outputs keep showing the last entry popped.
  assign {upd_pc, upd_taken, upd_mispred} = upd_valid ? mem[rd_ptr] : hold;

  // Redirect/flush pulse, illegal funct3 pulse and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
      err_funct3     <= 1'b0;
      ovf_sticky     <= 1'b0;
    end else begin
      redirect_valid <= mispred;
      flush          <= mispred;
      if (mispred) redirect_pc <= actual_npc;
      err_funct3     <= live & illegal;
      if (push & full & ~pop) ovf_sticky <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches <= '0;
      perf_mispreds <= '0;
    end else begin
      if (push && perf_branches != '1)    perf_branches <= perf_branches + 1'b1;
      if (mispred && perf_mispreds != '1) perf_mispreds <= perf_mispreds + 1'b1;
    end
  end

  // Update queue storage, pointers, occupancy and last-popped hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      hold   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_wr) begin
        mem[wr_ptr] <= {ex_pc, taken, mispred};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        hold   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_is_branch, ex_pred_taken, BrEq, BrLt, upd_ready;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target, ex_pred_npc;
  logic        BrUn, redirect_valid, flush, upd_valid, upd_taken, upd_mispred;
  logic        stall_req, err_funct3, ovf_sticky;
  logic [31:0] redirect_pc, upd_pc, perf_branches, perf_mispreds;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .FIFO_DEPTH(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_funct3(ex_funct3),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_npc(ex_pred_npc), .BrEq(BrEq), .BrLt(BrLt), .BrUn(BrUn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .stall_req(stall_req),
    .err_funct3(err_funct3), .ovf_sticky(ovf_sticky),
    .perf_branches(perf_branches), .perf_mispreds(perf_mispreds)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic is_br, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] pnpc,
                       input logic eq, input logic lt);
    ex_valid = 1'b1; ex_is_branch = is_br; ex_funct3 = f3; ex_pc = pc;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_npc = pnpc; BrEq = eq; BrLt = lt;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; upd_ready = 1'b0;
    ex_valid = 0; ex_is_branch = 0; ex_funct3 = 0; ex_pc = 0; ex_target = 0;
    ex_pred_taken = 0; ex_pred_npc = 0; BrEq = 0; BrLt = 0;
    #2;
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_perf_branches", perf_branches, 0);
    chk("rst_perf_mispreds", perf_mispreds, 0);
    chk("rst_ovf", ovf_sticky, 0);
    step(); step();
    rst = 1'b0;

    // BEQ equal, predicted fall-through -> mispredict to 0x80
    drive(1, 3'b000, 32'h100, 32'h80, 0, 32'h104, 1, 1);
    chk("beq_brun", BrUn, 0);
    step();
    idle();
    chk("beq_redirect_valid", redirect_valid, 1);
    chk("beq_flush", flush, 1);
    chk("beq_redirect_pc", redirect_pc, 32'h80);
    chk("beq_perf_mispreds", perf_mispreds, 1);
    chk("beq_perf_branches", perf_branches, 1);
    chk("beq_upd_valid", upd_valid, 1);
    chk("beq_upd_pc", upd_pc, 32'h100);
    chk("beq_upd_taken", upd_taken, 1);
    chk("beq_upd_mispred", upd_mispred, 1);
    step();
    chk("beq_redirect_drop", redirect_valid, 0);
    chk("beq_flush_drop", flush, 0);
    upd_ready = 1'b1;
    step();
    upd_ready = 1'b0;
    chk("pop_empty_valid", upd_valid, 0);
    chk("pop_empty_hold_pc", upd_pc, 32'h100);

    // BGE with equal operands and stale BrLt=1 -> taken, correctly predicted
    drive(1, 3'b101, 32'h200, 32'h240, 1, 32'h240, 1, 1);
    step();
    idle();
    chk("bge_no_redirect", redirect_valid, 0);
    chk("bge_upd_pc", upd_pc, 32'h200);
    chk("bge_upd_taken", upd_taken, 1);
    chk("bge_upd_mispred", upd_mispred, 0);
    chk("bge_perf_branches", perf_branches, 2);
    upd_ready = 1'b1;
    step();
    upd_ready = 1'b0;
    chk("bge_drained", upd_valid, 0);

    // BLTU not taken at top of address space, predicted taken -> redirect to wrapped 0
    drive(1, 3'b110, 32'hFFFF_FFFC, 32'h1000, 1, 32'h1000, 0, 0);
    chk("bltu_brun", BrUn, 1);
    step();
    chk("bltu_redirect_valid", redirect_valid, 1);
    chk("bltu_redirect_pc", redirect_pc, 32'h0);
    chk("bltu_upd_taken", upd_taken, 0);
    chk("bltu_upd_mispred", upd_mispred, 1);
    // Shadow: would mispredict, but must be ignored
    drive(1, 3'b000, 32'h300, 32'h400, 0, 32'h304, 1, 0);
    step();
    idle();
    chk("shadow_no_redirect", redirect_valid, 0);
    chk("shadow_perf_branches", perf_branches, 3);
    chk("shadow_perf_mispreds", perf_mispreds, 2);
    chk("shadow_head_pc", upd_pc, 32'hFFFF_FFFC);

    // Illegal funct3 -> err pulse, no count
    drive(1, 3'b010, 32'h400, 32'h800, 0, 32'h404, 1, 0);
    step();
    idle();
    chk("err_pulse", err_funct3, 1);
    chk("err_perf_branches", perf_branches, 3);
    step();
    chk("err_drop", err_funct3, 0);

    // Jump mispredict: redirect, counts mispred, no push
    drive(0, 3'b000, 32'h500, 32'h600, 0, 32'h504, 0, 0);
    step();
    idle();
    chk("jal_redirect_pc", redirect_pc, 32'h600);
    chk("jal_perf_mispreds", perf_mispreds, 3);
    chk("jal_perf_branches", perf_branches, 3);
    step();
    upd_ready = 1'b1;
    step();
    upd_ready = 1'b0;
    chk("jal_queue_empty", upd_valid, 0);

    // Fill the queue with four correctly predicted not-taken BEQs, then overflow
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'b000, 32'h1000 + 32'(i * 16), 32'h9000, 0, 32'h1004 + 32'(i * 16), 0, 0);
      step();
      if (i == 2) chk("fill3_stall", stall_req, 0);
    end
    chk("fill4_stall", stall_req, 1);
    drive(1, 3'b000, 32'h1040, 32'h9000, 0, 32'h1044, 0, 0);
    step();
    chk("ovf_sticky", ovf_sticky, 1);
    chk("ovf_head", upd_pc, 32'h1000);
    // Push and pop together while full
    drive(1, 3'b000, 32'h1050, 32'h9000, 0, 32'h1054, 0, 0);
    upd_ready = 1'b1;
    step();
    idle();
    chk("fullpp_stall", stall_req, 1);
    chk("fullpp_head", upd_pc, 32'h1010);
    chk("fullpp_perf_branches", perf_branches, 9);
    step();
    chk("drain_1020", upd_pc, 32'h1020);
    step();
    chk("drain_1030", upd_pc, 32'h1030);
    step();
    chk("drain_1050", upd_pc, 32'h1050);
    step();
    chk("drain_empty", upd_valid, 0);
    chk("drain_hold", upd_pc, 32'h1050);
    upd_ready = 1'b0;

    // Reset with three entries queued and a redirect pending
    drive(1, 3'b000, 32'h2000, 32'h9000, 0, 32'h2004, 0, 0);
    step();
    drive(1, 3'b000, 32'h2010, 32'h9000, 0, 32'h2014, 0, 0);
    step();
    drive(1, 3'b000, 32'h2020, 32'h2100, 0, 32'h2024, 1, 0);
    step();
    idle();
    chk("pre_rst_redirect", redirect_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_redirect", redirect_valid, 0);
    chk("rst_mid_flush", flush, 0);
    chk("rst_mid_redirect_pc", redirect_pc, 0);
    chk("rst_mid_upd_valid", upd_valid, 0);
    chk("rst_mid_upd_pc", upd_pc, 0);
    chk("rst_mid_perf_branches", perf_branches, 0);
    chk("rst_mid_ovf", ovf_sticky, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_upd_valid", upd_valid, 0);
    chk("post_rst_stall", stall_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
